// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single DMEM port between MEM-stage loads and STQ retirement, with fence drain.
// Optional macro DMEM_ARB_PERF_EN adds perf_ld_stall, a saturating count of stalled load cycles.
module dmem_port_arbiter #(
  parameter int unsigned AM       = 11,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ld_req,
  input  logic [AM-2:0] ld_addr,
  output logic          ld_gnt,
  input  logic          mem_stq_commit,
  input  logic          stq_mem_req,
  input  logic [AM-2:0] stq_mem_addr,
  input  logic [31:0]   stq_mem_data,
  input  logic [3:0]    stq_mem_wenb,
  output logic          stq_mem_ack,
  input  logic          fence_req,
  output logic          fence_done,
  output logic          dm_en,
  output logic [3:0]    dm_wenb,
  output logic [AM-2:0] dm_addr,
  output logic [31:0]   dm_wdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_ld_stall
`endif
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(MAX_WAIT + 1);
  localparam logic [OW-1:0] OCC_FULL   = OW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            st_win;

  // Zero-latency grant decision; outputs held quiet while reset is asserted.
  always_comb begin
    st_win      = reset_n & stq_mem_req &
                  ((state_q == DRAIN) | (occ_q == OCC_FULL) | (starve_q == STARVE_MAX) | ~ld_req);
    stq_mem_ack = st_win;
    ld_gnt      = reset_n & ld_req & ~st_win & (state_q == RUN);
  end

  // Occupancy, starvation and fence-drain next state.
  always_comb begin
    occ_d      = occ_q + OW'(mem_stq_commit) - OW'(st_win);
    starve_d   = '0;
    state_d    = state_q;
    fence_done = 1'b0;
    if (stq_mem_req & ~st_win) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
    end
    case (state_q)
      RUN: begin
        if (fence_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (occ_d == '0) begin
          state_d    = RUN;
          fence_done = reset_n;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // SRAM port mux: retiring store has priority over a granted load.
  always_comb begin
    dm_en    = 1'b0;
    dm_wenb  = '0;
    dm_addr  = '0;
    dm_wdata = '0;
    if (st_win) begin
      dm_en    = 1'b1;
      dm_wenb  = stq_mem_wenb;
      dm_addr  = stq_mem_addr;
      dm_wdata = stq_mem_data;
    end else if (ld_gnt) begin
      dm_en    = 1'b1;
      dm_addr  = ld_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      occ_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      starve_q <= starve_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (ld_req & ~ld_gnt & (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_ld_stall = perf_q;
`endif

  // A full STQ always wins the port, so a commit into it must coincide with a retirement.
  commit_when_full_a : assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_stq_commit && (occ_q == OCC_FULL) && !stq_mem_ack));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, reset-mid-drain sequence,
// and randomized traffic compared against a behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

  localparam int AM       = 11;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ld_req;
  logic [AM-2:0] ld_addr;
  logic          ld_gnt;
  logic          mem_stq_commit;
  logic          stq_mem_req;
  logic [AM-2:0] stq_mem_addr;
  logic [31:0]   stq_mem_data;
  logic [3:0]    stq_mem_wenb;
  logic          stq_mem_ack;
  logic          fence_req;
  logic          fence_done;
  logic          dm_en;
  logic [3:0]    dm_wenb;
  logic [AM-2:0] dm_addr;
  logic [31:0]   dm_wdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   perf_ld_stall;
`endif

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AM(AM), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_gnt         (ld_gnt),
    .mem_stq_commit (mem_stq_commit),
    .stq_mem_req    (stq_mem_req),
    .stq_mem_addr   (stq_mem_addr),
    .stq_mem_data   (stq_mem_data),
    .stq_mem_wenb   (stq_mem_wenb),
    .stq_mem_ack    (stq_mem_ack),
    .fence_req      (fence_req),
    .fence_done     (fence_done),
    .dm_en          (dm_en),
    .dm_wenb        (dm_wenb),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_ld_stall  (perf_ld_stall)
`endif
  );

  typedef struct {
    logic ld;
    logic commit;
    logic sreq;
    logic fence;
    logic exp_gnt;
    logic exp_ack;
    logic exp_done;
  } vec_t;

  vec_t vecs[17];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Behavioural model state: STQ fill level, cycles the current store has been refused,
  // whether a fence drain is in progress, and the expected stall count.
  int   m_occ, m_starve, m_perf;
  bit   m_drain;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [46:0] dm_exp(input bit gnt, input bit ack);
    if (ack)      return {1'b1, stq_mem_wenb, stq_mem_addr, stq_mem_data};
    else if (gnt) return {1'b1, 4'b0000, ld_addr, 32'h0};
    else          return '0;
  endfunction

  function automatic logic [46:0] dm_act();
    return {dm_en, dm_wenb, dm_addr, dm_wdata};
  endfunction

  function automatic void model_calc(output bit sw, output bit gnt, output bit done, output int nxt);
    sw   = stq_mem_req && (m_drain || m_occ == DEPTH || m_starve == MAX_WAIT || !ld_req);
    gnt  = ld_req && !sw && !m_drain;
    nxt  = m_occ + int'(mem_stq_commit) - int'(sw);
    done = m_drain && nxt == 0;
  endfunction

  function automatic void model_step();
    bit sw, gnt, done;
    int nxt;
    model_calc(sw, gnt, done, nxt);
    m_occ = nxt;
    if (stq_mem_req && !sw) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
    else                    m_starve = 0;
    if (!m_drain)    m_drain = fence_req;
    else if (done)   m_drain = 1'b0;
    if (ld_req && !gnt && m_perf < 65535) m_perf++;
  endfunction

  function automatic void model_reset();
    m_occ = 0; m_starve = 0; m_drain = 1'b0; m_perf = 0;
  endfunction

  task automatic rand_data();
    ld_addr      = AM'($urandom) & {(AM-1){1'b1}};
    stq_mem_addr = AM'($urandom) & {(AM-1){1'b1}};
    stq_mem_data = $urandom;
    stq_mem_wenb = 4'($urandom_range(1, 15));
  endtask

  task automatic idle_inputs();
    ld_req = 1'b0; mem_stq_commit = 1'b0; stq_mem_req = 1'b0; fence_req = 1'b0;
    ld_addr = '0; stq_mem_addr = '0; stq_mem_data = '0; stq_mem_wenb = '0;
  endtask

  // Inputs are set just after a rising edge; outputs are compared at the falling edge.
  task automatic run_cycle(input string name);
    bit sw, gnt, done;
    int nxt;
    @(negedge clk);
    model_calc(sw, gnt, done, nxt);
    chk({name, "_grant"}, 64'({ld_gnt, stq_mem_ack, fence_done}), 64'({gnt, sw, done}));
    chk({name, "_port"}, 64'(dm_act()), 64'(dm_exp(gnt, sw)));
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({ld_gnt, stq_mem_ack, fence_done, dm_act()}), 64'h0);
`ifdef DMEM_ARB_PERF_EN
    chk("reset_perf", 64'(perf_ld_stall), 64'h0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: loads win, starvation override, full STQ, fence drains.
    for (int i = 0; i < 17; i++) begin
      ld_req = vecs[i].ld; mem_stq_commit = vecs[i].commit;
      stq_mem_req = vecs[i].sreq; fence_req = vecs[i].fence;
      rand_data();
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 64'({ld_gnt, stq_mem_ack, fence_done}),
          64'({vecs[i].exp_gnt, vecs[i].exp_ack, vecs[i].exp_done}));
      chk($sformatf("vec%0d_port", i), 64'(dm_act()), 64'(dm_exp(vecs[i].exp_gnt, vecs[i].exp_ack)));
      model_step();
      @(posedge clk);
      #1;
    end

    // Reset while draining with one store outstanding.
    ld_req = 1'b1; mem_stq_commit = 1'b1; stq_mem_req = 1'b0; fence_req = 1'b0; rand_data();
    run_cycle("pre_drain_commit");
    ld_req = 1'b1; mem_stq_commit = 1'b0; stq_mem_req = 1'b1; fence_req = 1'b1; rand_data();
    run_cycle("pre_drain_fence");
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_drain_reset_outputs", 64'({ld_gnt, stq_mem_ack, fence_done, dm_act()}), 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      run_cycle($sformatf("post_reset_idle%0d", i));
    end
    ld_req = 1'b1; rand_data();
    run_cycle("post_reset_load");

    // Randomized traffic; a commit is always legal because a full STQ wins the port.
    for (int i = 0; i < 400; i++) begin
      ld_req         = ($urandom_range(0, 3) != 0);
      mem_stq_commit = ($urandom_range(0, 2) == 0);
      stq_mem_req    = (m_occ > 0);
      fence_req      = ($urandom_range(0, 9) == 0);
      rand_data();
      run_cycle($sformatf("rand%0d", i));
    end

`ifdef DMEM_ARB_PERF_EN
    idle_inputs();
    @(negedge clk);
    chk("perf_count", 64'(perf_ld_stall), 64'(m_perf));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
